seg7_scan_driver: RTL

Parametrised, time-multiplexed driver for a common-anode seven-segment display bank behind PNP anode switches. Both anodes and segments are active-low. The block latches a packed nibble/decimal-point/blank image and scans one digit per refresh slot. Each slot begins with an anti-ghosting guard interval. It decodes full hex and can suppress leading zeros. It sits between the stopwatch counting logic and the board pins, and generalises the fixed 8-digit, all-off display stub.

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg7_scan_driver.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and
// all-off helpers. Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0]  SEG_OFF = 7'b1111111;
    localparam logic [15:0] AN_OFF  = 16'hFFFF;

    // Entry n is the glyph for nibble n (concatenation lists F down to 0).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low seven-segment glyph, purely combinational (0 cycles).
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver with per-slot anti-ghost guard,
// blanking, dp and leading-zero suppression; all outputs registered (1 cycle).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_HZ     = 100_000_000,
    parameter int SLOT_HZ    = 8_000,
    parameter int GUARD_CYC  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [4*NUM_DIGITS-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_blank,
    input  logic                    i_lzs,
    input  logic                    i_load,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic [6:0]              o_seg,
    output logic                    o_dp,
    output logic                    o_frame
);

    localparam int DIV   = CLK_HZ / SLOT_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("seg7_scan_driver: NUM_DIGITS must be 1..16");
    end
    if (DIV < 2) begin : g_bad_div
        $error("seg7_scan_driver: CLK_HZ/SLOT_HZ must be at least 2");
    end
    if (GUARD_CYC >= DIV) begin : g_bad_guard
        $error("seg7_scan_driver: GUARD_CYC must be less than CLK_HZ/SLOT_HZ");
    end

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic                    sh_lzs;

    logic [3:0]            cur_nib;
    logic [6:0]            dec_seg;
    logic                  upper_zero;
    logic                  suppress;
    logic                  in_guard;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_next;
    logic                  dp_next;

    assign cur_nib = sh_digits[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // Shifting out the digits below idx leaves exactly "this digit and all above".
    assign upper_zero = ((sh_digits >> {idx, 2'b00}) == '0);
    assign suppress   = sh_lzs && (idx != '0) && upper_zero;
    assign in_guard   = (cnt < CNT_W'(GUARD_CYC));

    always_comb begin
        an_next  = AN_OFF[NUM_DIGITS-1:0];
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if (!in_guard) begin
            an_next = ~(NUM_DIGITS'(1) << idx);
            if (!sh_blank[idx]) begin
                seg_next = suppress ? SEG_OFF : dec_seg;
                dp_next  = ~sh_dp[idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt       <= '0;
            idx       <= '0;
            sh_digits <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_lzs    <= 1'b0;
            o_an      <= AN_OFF[NUM_DIGITS-1:0];
            o_seg     <= SEG_OFF;
            o_dp      <= 1'b1;
            o_frame   <= 1'b0;
        end else begin
            if (cnt == CNT_W'(DIV - 1)) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (i_load) begin
                sh_digits <= i_digits;
                sh_dp     <= i_dp;
                sh_blank  <= i_blank;
                sh_lzs    <= i_lzs;
            end
            o_an    <= an_next;
            o_seg   <= seg_next;
            o_dp    <= dp_next;
            o_frame <= (cnt == '0) && (idx == '0);
        end
    end

endmodule
